// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_pkg
//  Description : Shared constants, bus widths and FSM encodings for the
//                instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package if_fetch_unit_pkg;

    // Reset levels for the synchronous active-low reset
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    // Bus widths
    localparam int InstAddrBus = 16;
    localparam int InstBus     = 16;

    // Bubble instruction handed to decode
    localparam logic [InstBus-1:0] NopInst = 16'h0800;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage : if_fetch_unit_pkg
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_if
//  Description : Instruction-memory read bus (req/ack handshake) between the
//                fetch unit (master) and instruction memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic                   imem_req_o;
    logic [InstAddrBus-1:0] imem_addr_o;
    logic [InstBus-1:0]     imem_rdata_i;
    logic                   imem_ack_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rdata_i,
        input  imem_ack_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rdata_i,
        output imem_ack_i
    );

endinterface : if_fetch_unit_if
`default_nettype wire

// File: rtl/if_fetch_unit_next_pc.sv
`default_nettype none
// ============================================================================
//  Module      : if_next_pc
//  Description : Next fetch address selection applied when a fetch is
//                acknowledged: pending delay-slot branch first, then a live
//                unstalled branch, otherwise sequential PC+1 (wraps at 2^16).
//  Revision    : 1.0  initial release
// ============================================================================
module if_next_pc
    import if_fetch_unit_pkg::*;
(
    input  wire logic [InstAddrBus-1:0] i_pc,
    input  wire logic                   i_pend_v,
    input  wire logic [InstAddrBus-1:0] i_pend_addr,
    input  wire logic                   i_branch_flag,
    input  wire logic                   i_stall,
    input  wire logic [InstAddrBus-1:0] i_branch_addr,
    output logic      [InstAddrBus-1:0] o_pc_inc,
    output logic      [InstAddrBus-1:0] o_next_pc
);

    // Sequential successor; natural 16-bit overflow gives the wrap
    assign o_pc_inc = i_pc + 16'd1;

    // Priority mux: pending target, then unstalled branch, then PC+1
    always_comb begin
        o_next_pc = o_pc_inc;
        if (i_pend_v) begin
            o_next_pc = i_pend_addr;
        end else if (i_branch_flag && !i_stall) begin
            o_next_pc = i_branch_addr;
        end
    end

endmodule : if_next_pc
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, runs the req/ack read
//                handshake to instruction memory, skid-buffers a fetch that
//                lands during a stall and drives the IF/ID register. Honours
//                one branch delay slot.
//                Optional macro IF_PERF_CNT_EN adds saturating fetch/wait
//                performance counters (perf_fetch_o, perf_wait_o).
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 16'h0000,
    parameter logic [InstBus-1:0]     NOP_INST = NopInst
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   stall_i,
    input  wire logic                   branch_flag_i,
    input  wire logic [InstAddrBus-1:0] branch_addr_i,
    if_fetch_unit_if.master             imem,
    output logic      [InstAddrBus-1:0] pc_o,
    output logic      [InstBus-1:0]     inst_o,
    output logic                        valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic      [15:0]            perf_fetch_o,
    output logic      [15:0]            perf_wait_o
`endif
);

    fetch_state_t r_state, w_state_nxt;

    logic [InstAddrBus-1:0] r_pc,        w_pc_nxt;
    logic                   r_pend_v,    w_pend_v_nxt;
    logic [InstAddrBus-1:0] r_pend_addr, w_pend_addr_nxt;
    logic [InstBus-1:0]     r_buf,       w_buf_nxt;
    logic [InstAddrBus-1:0] r_bufpc,     w_bufpc_nxt;
    logic [InstBus-1:0]     r_inst,      w_inst_nxt;
    logic [InstAddrBus-1:0] r_pc_out,    w_pc_out_nxt;
    logic                   r_valid,     w_valid_nxt;

    logic                   w_req;
    logic                   w_branch_take;
    logic [InstAddrBus-1:0] w_pc_inc;
    logic [InstAddrBus-1:0] w_next_pc;

    // A branch is honoured only when unstalled and no delay-slot target is pending
    assign w_branch_take = branch_flag_i && !stall_i && !r_pend_v;

    if_next_pc u_next_pc (
        .i_pc          (r_pc),
        .i_pend_v      (r_pend_v),
        .i_pend_addr   (r_pend_addr),
        .i_branch_flag (branch_flag_i),
        .i_stall       (stall_i),
        .i_branch_addr (branch_addr_i),
        .o_pc_inc      (w_pc_inc),
        .o_next_pc     (w_next_pc)
    );

    // Memory request is suppressed while reset is held
    assign imem.imem_req_o  = w_req && (rst == RstDisable);
    assign imem.imem_addr_o = r_pc;

    assign pc_o    = r_pc_out;
    assign inst_o  = r_inst;
    assign valid_o = r_valid;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, PC, skid buffer and IF/ID register updates
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_v_nxt    = r_pend_v;
        w_pend_addr_nxt = r_pend_addr;
        w_buf_nxt       = r_buf;
        w_bufpc_nxt     = r_bufpc;
        w_inst_nxt      = r_inst;
        w_pc_out_nxt    = r_pc_out;
        w_valid_nxt     = r_valid;
        w_req           = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                // Delay slot already fetched: redirect the PC directly
                if (w_branch_take) begin
                    w_pc_nxt = branch_addr_i;
                end
            end

            REQ: begin
                w_req = 1'b1;
                if (imem.imem_ack_i) begin
                    w_pc_nxt     = w_next_pc;
                    w_pend_v_nxt = 1'b0;
                    if (stall_i) begin
                        // Park the returned word until decode can take it
                        w_buf_nxt   = imem.imem_rdata_i;
                        w_bufpc_nxt = w_pc_inc;
                        w_state_nxt = HOLD;
                    end else begin
                        w_inst_nxt   = imem.imem_rdata_i;
                        w_pc_out_nxt = w_pc_inc;
                        w_valid_nxt  = 1'b1;
                    end
                end else if (!stall_i) begin
                    w_inst_nxt  = NOP_INST;
                    w_valid_nxt = 1'b0;
                    // In-flight fetch is the delay slot; remember the target
                    if (w_branch_take) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_addr_nxt = branch_addr_i;
                    end
                end
            end

            HOLD: begin
                if (!stall_i) begin
                    w_inst_nxt   = r_buf;
                    w_pc_out_nxt = r_bufpc;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = REQ;
                    if (w_branch_take) begin
                        w_pc_nxt = branch_addr_i;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_pc        <= RESET_PC;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_buf       <= NOP_INST;
            r_bufpc     <= '0;
            r_inst      <= NOP_INST;
            r_pc_out    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_buf       <= w_buf_nxt;
            r_bufpc     <= w_bufpc_nxt;
            r_inst      <= w_inst_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

`ifndef SYNTHESIS
    // Flag software that places a branch in a delay slot
    always_ff @(posedge clk) begin
        if ((rst == RstDisable) && r_pend_v && branch_flag_i && !stall_i) begin
            $error("if_fetch_unit: branch in delay slot at pc=%h dropped", r_pc);
        end
    end
`endif

`ifdef IF_PERF_CNT_EN
    logic        w_fetch_acc;
    logic        w_wait_cyc;
    logic [15:0] r_perf_fetch;
    logic [15:0] r_perf_wait;

    assign w_fetch_acc = (r_state == REQ) && imem.imem_ack_i;
    assign w_wait_cyc  = (r_state == REQ) && !imem.imem_ack_i;

    // Saturating fetch and wait-state counters
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_perf_fetch <= '0;
            r_perf_wait  <= '0;
        end else begin
            if (w_fetch_acc && (r_perf_fetch != 16'hFFFF)) begin
                r_perf_fetch <= r_perf_fetch + 16'd1;
            end
            if (w_wait_cyc && (r_perf_wait != 16'hFFFF)) begin
                r_perf_wait <= r_perf_wait + 16'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_wait_o  = r_perf_wait;
`endif

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Directed self-checking bench for if_fetch_unit with an
//                expected-output scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [15:0] branch_addr_i;
    logic [15:0] pc_o;
    logic [15:0] inst_o;
    logic        valid_o;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_o;
    logic [15:0] perf_wait_o;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    if_fetch_unit_if imem_bus ();

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .imem          (imem_bus),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_wait_o   (perf_wait_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, check the request side, push expected
    // IF/ID contents, then pop and compare them after the rising edge.
    task automatic cycle(input logic r, input logic st, input logic bf,
                         input logic [15:0] ba, input logic ack, input logic [15:0] rd,
                         input logic e_req, input logic [15:0] e_addr,
                         input logic [15:0] e_inst, input logic [15:0] e_pc,
                         input logic e_valid);
        exp_t e;
        rst                   = r;
        stall_i               = st;
        branch_flag_i         = bf;
        branch_addr_i         = ba;
        imem_bus.imem_ack_i   = ack;
        imem_bus.imem_rdata_i = rd;
        #1;
        chk("imem_req", {15'd0, imem_bus.imem_req_o}, {15'd0, e_req});
        if (e_req) chk("imem_addr", imem_bus.imem_addr_o, e_addr);
        sb_q.push_back('{inst: e_inst, pc: e_pc, valid: e_valid});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("inst_o", inst_o, e.inst);
        chk("pc_o", pc_o, e.pc);
        chk("valid_o", {15'd0, valid_o}, {15'd0, e.valid});
        @(negedge clk);
    endtask

    initial begin
        rst                   = 1'b0;
        stall_i               = 1'b0;
        branch_flag_i         = 1'b0;
        branch_addr_i         = 16'h0000;
        imem_bus.imem_ack_i   = 1'b0;
        imem_bus.imem_rdata_i = 16'h0000;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", {15'd0, valid_o}, 16'd0);
        chk("rst_pc", pc_o, 16'h0000);
        chk("rst_req", {15'd0, imem_bus.imem_req_o}, 16'd0);
        @(negedge clk);

        //     rst  st  bf  ba        ack rdata     req addr      inst      pc        v
        // IDLE after release: no request, stray ack ignored
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'hDEAD, 0, 16'h0000, NOP,      16'h0000, 0);
        // Zero-wait stream
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h6911, 1, 16'h0000, 16'h6911, 16'h0001, 1);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h6912, 1, 16'h0001, 16'h6912, 16'h0002, 1);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0002, 16'h1111, 16'h0003, 1);
        // Two wait states at address 3
        cycle(1'b1, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 16'h0003, NOP,      16'h0003, 0);
        cycle(1'b1, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 16'h0003, NOP,      16'h0003, 0);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0003, 16'h2222, 16'h0004, 1);
        // Stall coinciding with ack: buffered, outputs held, request drops
        cycle(1'b1, 1, 0, 16'h0000, 1, 16'h4A05, 1, 16'h0004, 16'h2222, 16'h0004, 1);
        cycle(1'b1, 1, 0, 16'h0000, 1, 16'hDEAD, 0, 16'h0000, 16'h2222, 16'h0004, 1);
        cycle(1'b1, 0, 0, 16'h0000, 0, 16'hDEAD, 0, 16'h0000, 16'h4A05, 16'h0005, 1);
        // Branch with ack: 0005 delivered, redirect to 0040
        cycle(1'b1, 0, 1, 16'h0040, 1, 16'h3333, 1, 16'h0005, 16'h3333, 16'h0006, 1);
        // Branch back to 0005 (delay slot at 0040)
        cycle(1'b1, 0, 1, 16'h0005, 1, 16'h3434, 1, 16'h0040, 16'h3434, 16'h0041, 1);
        // Branch during wait: pend latched, address holds at 0005
        cycle(1'b1, 0, 1, 16'h0040, 0, 16'hBEEF, 1, 16'h0005, NOP,      16'h0041, 0);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0005, 16'h5555, 16'h0006, 1);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h5656, 1, 16'h0040, 16'h5656, 16'h0041, 1);
        // Wrap at 16'hFFFF
        cycle(1'b1, 0, 1, 16'hFFFF, 1, 16'h7777, 1, 16'h0041, 16'h7777, 16'h0042, 1);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'h8888, 1, 16'hFFFF, 16'h8888, 16'h0000, 1);
        // Branch masked by stall (REQ with ack, then HOLD)
        cycle(1'b1, 1, 1, 16'h0123, 1, 16'h9999, 1, 16'h0000, 16'h8888, 16'h0000, 1);
        cycle(1'b1, 1, 1, 16'h0123, 0, 16'hDEAD, 0, 16'h0000, 16'h8888, 16'h0000, 1);
        cycle(1'b1, 0, 0, 16'h0000, 0, 16'hDEAD, 0, 16'h0000, 16'h9999, 16'h0001, 1);
        // Branch masked by stall during a wait state: no pend
        cycle(1'b1, 1, 1, 16'h0200, 0, 16'hDEAD, 1, 16'h0001, 16'h9999, 16'h0001, 1);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h0001, 16'hAAAA, 16'h0002, 1);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'hBBBB, 1, 16'h0002, 16'hBBBB, 16'h0003, 1);
        // Reset mid-request, late ack ignored, fetch restarts at RESET_PC
        cycle(1'b0, 0, 0, 16'h0000, 0, 16'hDEAD, 0, 16'h0000, NOP,      16'h0000, 0);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'hDEAD, 0, 16'h0000, NOP,      16'h0000, 0);
        cycle(1'b1, 0, 0, 16'h0000, 1, 16'hCCCC, 1, 16'h0000, 16'hCCCC, 16'h0001, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_if_fetch_unit
`default_nettype wire
